memory_arbiter: RTL

Shares the single external memory port between the three pipeline clients that touch memory: instruction fetch, the read stage (loads, and the read half of CX), and the write stage (stores). Each client holds its request and address stable until it receives a one-cycle completion pulse, the same valid/hold style the pipeline stages already use. The arbiter serialises clients onto one outstanding memory transaction at a time and routes returning read data back to the client that owns it.

---
 rtl/memory_arbiter_if.sv | 34 +++
 rtl/memory_arbiter.sv | 82 ++++++++
 2 files changed

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: client request/completion signals and the external memory port of memory_arbiter.
interface memory_arbiter_if #(parameter int WIDTH = 32);
    logic             fetch_enable;
    logic [WIDTH-1:0] fetch_address;
    logic             fetch_valid;
    logic [WIDTH-1:0] fetch_data;
    logic             read_enable;
    logic [WIDTH-1:0] read_address;
    logic             read_valid;
    logic [WIDTH-1:0] read_data;
    logic             write_enable;
    logic [WIDTH-1:0] write_address;
    logic [WIDTH-1:0] write_data;
    logic             write_done;
    logic             mem_enable;
    logic             mem_write;
    logic [WIDTH-1:0] mem_address;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ready;
    logic             mem_data_valid;
    logic [WIDTH-1:0] mem_rdata;
    modport slave (
        input  fetch_enable, fetch_address, read_enable, read_address,
               write_enable, write_address, write_data, mem_ready, mem_data_valid, mem_rdata,
        output fetch_valid, fetch_data, read_valid, read_data, write_done,
               mem_enable, mem_write, mem_address, mem_wdata
    );
    modport master (
        output fetch_enable, fetch_address, read_enable, read_address,
               write_enable, write_address, write_data, mem_ready, mem_data_valid, mem_rdata,
        input  fetch_valid, fetch_data, read_valid, read_data, write_done,
               mem_enable, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises fetch, read and write clients onto one outstanding memory transaction.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for rotating grants instead of fixed write > read > fetch priority.
module memory_arbiter (
    input logic             clock,
    input logic             reset_n,
    memory_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
    typedef enum logic [1:0] {NONE, FETCH, READ, WRITE} owner_t;
    state_t state;
    owner_t owner;
    owner_t sel;
    logic   owner_live;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    owner_t last;
    // search fetch -> read -> write cyclically, starting after the last grant
    always_comb begin
        sel = NONE;
        case (last)
            FETCH:   sel = bus.read_enable ? READ : bus.write_enable ? WRITE : bus.fetch_enable ? FETCH : NONE;
            READ:    sel = bus.write_enable ? WRITE : bus.fetch_enable ? FETCH : bus.read_enable ? READ : NONE;
            default: sel = bus.fetch_enable ? FETCH : bus.read_enable ? READ : bus.write_enable ? WRITE : NONE;
        endcase
    end
`else
    always_comb sel = bus.write_enable ? WRITE : bus.read_enable ? READ : bus.fetch_enable ? FETCH : NONE;
`endif
    // a flushed owner has dropped its enable, so its completion is swallowed
    always_comb owner_live = owner == FETCH ? bus.fetch_enable : owner == READ ? bus.read_enable :
                             owner == WRITE ? bus.write_enable : 1'b0;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            owner           <= NONE;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            last            <= FETCH;
`endif
            bus.mem_enable  <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_wdata   <= '0;
            bus.fetch_valid <= 1'b0;
            bus.read_valid  <= 1'b0;
            bus.write_done  <= 1'b0;
            bus.fetch_data  <= '0;
            bus.read_data   <= '0;
        end else begin
            case (state)
                IDLE: if (sel != NONE) begin
                    state           <= ISSUE;
                    owner           <= sel;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
                    last            <= sel;
`endif
                    bus.mem_enable  <= 1'b1;
                    bus.mem_write   <= sel == WRITE;
                    bus.mem_address <= sel == WRITE ? bus.write_address : sel == READ ? bus.read_address : bus.fetch_address;
                    bus.mem_wdata   <= sel == WRITE ? bus.write_data : '0;
                end
                ISSUE: if (bus.mem_ready) begin
                    state          <= bus.mem_write ? RESPOND : WAIT;
                    bus.mem_enable <= 1'b0;
                    bus.write_done <= bus.mem_write && owner_live;
                end
                WAIT: if (bus.mem_data_valid) begin
                    state           <= RESPOND;
                    if (owner == FETCH) bus.fetch_data <= bus.mem_rdata;
                    if (owner == READ) bus.read_data <= bus.mem_rdata;
                    bus.fetch_valid <= owner == FETCH && owner_live;
                    bus.read_valid  <= owner == READ && owner_live;
                end
                RESPOND: begin
                    state           <= IDLE;
                    owner           <= NONE;
                    bus.fetch_valid <= 1'b0;
                    bus.read_valid  <= 1'b0;
                    bus.write_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
